pattern_counter_array: RTL and testbench

Multi-channel, parametrised successor of the single-shot pattern counter. Each channel is loaded with a base value, a step mode and a length. It then autonomously emits a sequence of base+delta, base+2·delta, and so on. Channels share one registered output port with valid/ready back-pressure and round-robin arbitration. The block sits between the pattern configuration logic and the pattern address consumers.

---
 rtl/pattern_pkg.sv | 42 ++++
 rtl/pattern_rr_arb.sv | 55 +++++
 rtl/pattern_counter_array.sv | 166 ++++++++++++++++
 tb/tb_pattern_counter_array.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pattern_pkg
// Purpose  : Shared types and helpers for the pattern counter array:
//            step-mode encoding, delta decode, per-channel state type.
// Revision : 1.0 - initial release
// ============================================================================
package pattern_pkg;

  // Step-mode field as presented on the configuration port
  typedef enum logic [1:0] {
    XM_ZERO  = 2'b00,
    XM_ONE   = 2'b01,
    XM_FOUR  = 2'b10,
    XM_EIGHT = 2'b11
  } xmode_e;

  // Per-channel sequencer state
  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // Largest decoded step is 8, so four bits hold every delta
  localparam int c_DELTA_W = 4;

  // Map the step mode onto the per-beat increment
  function automatic logic [c_DELTA_W-1:0] delta_decode(input xmode_e xm);
    logic [c_DELTA_W-1:0] d;
    d = '0;
    unique case (xm)
      XM_ZERO:  d = 4'd0;
      XM_ONE:   d = 4'd1;
      XM_FOUR:  d = 4'd4;
      XM_EIGHT: d = 4'd8;
      default:  d = 4'd0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : pattern_rr_arb
// Purpose  : Round-robin arbiter. Grants the first requester at or after the
//            pointer; the pointer moves one past the winner on each grant.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_rr_arb #(
  parameter int CH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH-1:0]         i_req,
  input  logic                  i_en,
  output logic [CH-1:0]         o_gnt,
  output logic [$clog2(CH)-1:0] o_gnt_idx,
  output logic                  o_gnt_vld
);

  localparam int c_IDX_W = $clog2(CH);

  logic [c_IDX_W-1:0] r_ptr;

  // Rotating priority search starting at the pointer
  always_comb begin
    int  w_idx;
    logic w_found;
    w_idx     = 0;
    w_found   = 1'b0;
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    for (int i = 0; i < CH; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= CH) w_idx = w_idx - CH;
      if (i_en && !w_found && i_req[c_IDX_W'(w_idx)]) begin
        w_found                 = 1'b1;
        o_gnt[c_IDX_W'(w_idx)]  = 1'b1;
        o_gnt_idx               = c_IDX_W'(w_idx);
        o_gnt_vld               = 1'b1;
      end
    end
  end

  // Pointer moves to the channel after the winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (o_gnt_vld) begin
      r_ptr <= (o_gnt_idx == c_IDX_W'(CH - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pattern_counter_array.sv
`default_nettype none
// ============================================================================
// Module   : pattern_counter_array
// Purpose  : CH independent arithmetic-sequence generators sharing one
//            registered valid/ready output through a round-robin arbiter.
//            Optional macro PATTERN_SAT_EN: saturating arithmetic plus a
//            sticky out_sat flag.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_counter_array
  import pattern_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CH    = 4,
  parameter int LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [$clog2(CH)-1:0] cfg_ch,
  input  logic [WIDTH-1:0]      cfg_base,
  input  logic [1:0]            cfg_xmode,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_val,
  output logic [$clog2(CH)-1:0] out_ch,
  output logic                  out_last,
`ifdef PATTERN_SAT_EN
  output logic                  out_sat,
`endif
  output logic [CH-1:0]         busy
);

  localparam int c_IDX_W = $clog2(CH);

  logic [CH-1:0]      w_busy;
  logic [CH-1:0]      w_gnt;
  logic [c_IDX_W-1:0] w_gnt_idx;
  logic               w_gnt_vld;
  logic [WIDTH-1:0]   w_nxt_val [CH];
  logic [CH-1:0]      w_is_last;
  logic               w_cfg_acc;
  logic               w_load_ok;
`ifdef PATTERN_SAT_EN
  logic [CH-1:0]      w_sat_evt;
  logic               r_out_sat;
`endif

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_val;
  logic [c_IDX_W-1:0] r_out_ch;
  logic               r_out_last;

  // Output register can take a new beat when empty or being drained
  assign w_load_ok = !r_out_valid || out_ready;
  // Abort blocks any simultaneous configuration
  assign cfg_ready = !abort && !w_busy[cfg_ch];
  assign w_cfg_acc = cfg_valid && cfg_ready;

  pattern_rr_arb #(.CH(CH)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_busy),
    .i_en      (w_load_ok && !abort),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  for (genvar g = 0; g < CH; g++) begin : g_ch
    ch_state_e            r_state;
    ch_state_e            w_state_nxt;
    logic [WIDTH-1:0]     r_acc;
    logic [c_DELTA_W-1:0] r_delta;
    logic [LEN_W-1:0]     r_rem;
    logic                 w_sel;

    assign w_sel        = w_cfg_acc && (cfg_ch == c_IDX_W'(g));
    assign w_busy[g]    = (r_state == CH_RUN);
    assign w_is_last[g] = (r_rem == '0);

`ifdef PATTERN_SAT_EN
    logic [WIDTH:0] w_sum;
    assign w_sum        = {1'b0, r_acc} + (WIDTH + 1)'(r_delta);
    assign w_sat_evt[g] = w_sum[WIDTH];
    assign w_nxt_val[g] = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
`else
    assign w_nxt_val[g] = r_acc + WIDTH'(r_delta);
`endif

    // Next state: start on accept, stop after last grant, abort overrides
    always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
        CH_IDLE: if (w_sel) w_state_nxt = CH_RUN;
        CH_RUN:  if (w_gnt[g] && w_is_last[g]) w_state_nxt = CH_IDLE;
        default: w_state_nxt = CH_IDLE;
      endcase
      if (abort) w_state_nxt = CH_IDLE;
    end

    // Channel state register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= CH_IDLE;
      else        r_state <= w_state_nxt;
    end

    // Sequence datapath: load on accept, advance on each grant
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc   <= '0;
        r_delta <= '0;
        r_rem   <= '0;
      end else if (w_sel) begin
        r_acc   <= cfg_base;
        r_delta <= delta_decode(xmode_e'(cfg_xmode));
        r_rem   <= cfg_len;
      end else if (w_gnt[g]) begin
        r_acc   <= w_nxt_val[g];
        r_rem   <= r_rem - LEN_W'(1);
      end
    end
  end

  // Shared output register; contents hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_val   <= '0;
      r_out_ch    <= '0;
      r_out_last  <= 1'b0;
`ifdef PATTERN_SAT_EN
      r_out_sat   <= 1'b0;
`endif
    end else if (abort) begin
      r_out_valid <= 1'b0;
`ifdef PATTERN_SAT_EN
      r_out_sat   <= 1'b0;
`endif
    end else if (w_gnt_vld) begin
      r_out_valid <= 1'b1;
      r_out_val   <= w_nxt_val[w_gnt_idx];
      r_out_ch    <= w_gnt_idx;
      r_out_last  <= w_is_last[w_gnt_idx];
`ifdef PATTERN_SAT_EN
      r_out_sat   <= r_out_sat | w_sat_evt[w_gnt_idx];
`endif
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_val   = r_out_val;
  assign out_ch    = r_out_ch;
  assign out_last  = r_out_last;
  assign busy      = w_busy;
`ifdef PATTERN_SAT_EN
  assign out_sat   = r_out_sat;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pattern_counter_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_counter_array
// Purpose  : Directed and random stimulus for pattern_counter_array, checked
//            cycle by cycle against a behavioural sequence model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_counter_array;

  localparam int WIDTH = 12;
  localparam int CH    = 4;
  localparam int LEN_W = 8;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_ch = '0;
  logic [WIDTH-1:0] cfg_base = '0;
  logic [1:0]       cfg_xmode = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             abort = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_val;
  logic [1:0]       out_ch;
  logic             out_last;
  logic [CH-1:0]    busy;
`ifdef PATTERN_SAT_EN
  logic             out_sat;
`endif

  pattern_counter_array #(.WIDTH(WIDTH), .CH(CH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_base  (cfg_base),
    .cfg_xmode (cfg_xmode),
    .cfg_len   (cfg_len),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_ch    (out_ch),
    .out_last  (out_last),
`ifdef PATTERN_SAT_EN
    .out_sat   (out_sat),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: each channel tracks how many beats it has produced
  int m_base [CH];
  int m_delta[CH];
  int m_len  [CH];
  int m_n    [CH];
  bit m_run  [CH];
  int m_ptr;
  bit m_ov;
  int m_val;
  int m_ch;
  bit m_last;
  bit m_sat;

  int n_tests = 0;
  int n_fail  = 0;
  int lg_val[$];
  int lg_ch [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dec(input int xm);
    case (xm)
      0: return 0;
      1: return 1;
      2: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [CH-1:0] busy_vec();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = m_run[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_base[i] = 0; m_delta[i] = 0; m_len[i] = 0; m_n[i] = 0; m_run[i] = 0;
    end
    m_ptr = 0; m_ov = 0; m_val = 0; m_ch = 0; m_last = 0; m_sat = 0;
  endtask

  task automatic model_grant(input int k);
    int v;
    v = m_base[k] + (m_n[k] + 1) * m_delta[k];
`ifdef PATTERN_SAT_EN
    if (v > MAXV) begin
      v = MAXV;
      m_sat = 1;
    end
`else
    v = v % (MAXV + 1);
`endif
    m_val  = v;
    m_ch   = k;
    m_last = (m_n[k] == m_len[k]);
    m_n[k]++;
    if (m_last) m_run[k] = 0;
    m_ov  = 1;
    m_ptr = (k + 1) % CH;
  endtask

  task automatic model_step(input int cv, input int ch, input int base, input int xm,
                            input int len, input int ab, input int ordy);
    bit accept;
    bit found;
    int k;
    accept = (cv != 0) && (ab == 0) && !m_run[ch];
    if (ab != 0) begin
      for (int i = 0; i < CH; i++) m_run[i] = 0;
      m_ov  = 0;
      m_sat = 0;
    end else begin
      found = 0;
      if (!m_ov || ordy != 0) begin
        for (int i = 0; i < CH; i++) begin
          k = (m_ptr + i) % CH;
          if (!found && m_run[k]) begin
            found = 1;
            model_grant(k);
          end
        end
      end
      if (!found && ordy != 0) m_ov = 0;
      if (accept) begin
        m_run[ch]   = 1;
        m_base[ch]  = base;
        m_delta[ch] = dec(xm);
        m_len[ch]   = len;
        m_n[ch]     = 0;
      end
    end
  endtask

  // One clock: drive at negedge, compare registered outputs, advance model
  task automatic cycle(input int cv, input int ch, input int base, input int xm,
                       input int len, input int ab, input int ordy);
    cfg_valid = (cv != 0);
    cfg_ch    = 2'(ch);
    cfg_base  = WIDTH'(base);
    cfg_xmode = 2'(xm);
    cfg_len   = LEN_W'(len);
    abort     = (ab != 0);
    out_ready = (ordy != 0);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_val",   32'(out_val),   32'(m_val));
    check("out_ch",    32'(out_ch),    32'(m_ch));
    check("out_last",  32'(out_last),  32'(m_last));
    check("busy",      32'(busy),      32'(busy_vec()));
    check("cfg_ready", 32'(cfg_ready), 32'((ab == 0) && !m_run[ch]));
`ifdef PATTERN_SAT_EN
    check("out_sat",   32'(out_sat),   32'(m_sat));
`endif
    if (out_valid && ordy != 0 && ab == 0) begin
      lg_val.push_back(int'(out_val));
      lg_ch.push_back(int'(out_ch));
    end
    model_step(cv, ch, base, xm, len, ab, ordy);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input int ordy);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, ordy);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_val"},   32'(out_val),   32'd0);
    check({tag, "_out_ch"},    32'(out_ch),    32'd0);
    check({tag, "_out_last"},  32'(out_last),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
`ifdef PATTERN_SAT_EN
    check({tag, "_out_sat"},   32'(out_sat),   32'd0);
`endif
  endtask

  initial begin
    int e0[4];
    int e1[2];
    int c1[$];
    int c2[$];

    // Reset
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    // ch0 base 0x100 step 4 len 3
    lg_val.delete(); lg_ch.delete();
    cycle(1, 0, 'h100, 2, 3, 0, 1);
    idle(6, 1);
    e0 = '{'h104, 'h108, 'h10C, 'h110};
    check("ch0_cnt", 32'(lg_val.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("ch0_beat", 32'(lg_val[i]), 32'(e0[i]));

    // ch1 near the top of the range, step 8 len 1
    lg_val.delete(); lg_ch.delete();
    cycle(1, 1, 'hFFC, 3, 1, 0, 1);
    idle(5, 1);
`ifdef PATTERN_SAT_EN
    e1 = '{'hFFF, 'hFFF};
    check("ch1_sat_flag", 32'(out_sat), 32'd1);
`else
    e1 = '{'h004, 'h00C};
`endif
    check("ch1_cnt", 32'(lg_val.size()), 32'd2);
    for (int i = 0; i < 2; i++) check("ch1_beat", 32'(lg_val[i]), 32'(e1[i]));

    // Back-pressure: ch0 len 5 step 1, stall 3 cycles after beat 2 appears
    lg_val.delete(); lg_ch.delete();
    cycle(1, 0, 'h20, 1, 5, 0, 1);
    idle(2, 1);
    idle(3, 0);
    idle(8, 1);
    check("bp_cnt", 32'(lg_val.size()), 32'd6);
    for (int i = 0; i < 6; i++) check("bp_beat", 32'(lg_val[i]), 32'('h21 + i));

    // Two channels interleaving
    lg_val.delete(); lg_ch.delete();
    cycle(1, 1, 0, 1, 3, 0, 1);
    cycle(1, 2, 'h7, 0, 3, 0, 1);
    idle(10, 1);
    for (int i = 0; i < lg_val.size(); i++) begin
      if (lg_ch[i] == 1) c1.push_back(lg_val[i]);
      if (lg_ch[i] == 2) c2.push_back(lg_val[i]);
    end
    check("il_ch1_cnt", 32'(c1.size()), 32'd4);
    check("il_ch2_cnt", 32'(c2.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("il_ch1_beat", 32'(c1[i]), 32'(i + 1));
      check("il_ch2_beat", 32'(c2[i]), 32'h7);
    end

    // Abort mid-sequence with a config to an idle channel
    cycle(1, 0, 0, 1, 20, 0, 1);
    idle(3, 1);
    cycle(1, 3, 'h55, 1, 2, 1, 1);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ov",   32'(out_valid), 32'd0);
    idle(1, 1);

    // Config repeatedly targeting a running channel
    cycle(1, 2, 'h10, 1, 2, 0, 1);
    for (int i = 0; i < 8; i++) cycle(1, 2, 'h30, 1, 0, 0, 1);
    idle(6, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 3) == 0 ? 1 : 0, int'($urandom % CH), int'($urandom % 4096),
            int'($urandom % 4), int'($urandom % 6), ($urandom % 50) == 0 ? 1 : 0,
            ($urandom % 4) != 0 ? 1 : 0);
    end

    // Reset mid-stream while a beat is being presented
    cycle(1, 0, 'h200, 1, 30, 0, 1);
    idle(3, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("arst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(3, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
